// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane-mask helper for the data-memory responder
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_e;

  function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] addr);
    case (size)
      SZ_B, SZ_BU: lane_mask = 4'b0001 << addr;
      SZ_H, SZ_HU: lane_mask = 4'b0011 << {addr[1], 1'b0};
      default:     lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_resp_load_ext.sv
// rtl/data_mem_resp_load_ext.sv - load lane select with sign/zero extension
module load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  mem_size_e   size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    result = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   result = {24'b0, byte_sel};
      SZ_H:    result = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   result = {16'b0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - load/store responder with fixed latency; DMEM_MISALIGN_TRAP_EN enables error responses
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e state;
  logic [3:0]  cnt;
  logic [31:0] pend_data;
  logic        pend_err;

  mem_size_e   eff_size;
  logic [1:0]  eff_lo;
  logic        req_err;
  logic        accept;
  logic [AW-1:0] idx;
  logic [3:0]  mask;
  logic [31:0] wdata_rep;
  logic [31:0] ext_data;
  logic [31:0] acc_data;

  wire unused_addr_hi = ^req_addr[31:AW+2];

  assign accept = req_valid && req_ready && rst_n;
  assign idx    = req_addr[AW+1:2];

  // Illegal sizes behave as W; lane offset is force-aligned to the access size.
  always_comb begin
    case (req_size)
      3'b000:  eff_size = SZ_B;
      3'b001:  eff_size = SZ_H;
      3'b100:  eff_size = SZ_BU;
      3'b101:  eff_size = SZ_HU;
      default: eff_size = SZ_W;
    endcase
    case (eff_size)
      SZ_B, SZ_BU: eff_lo = req_addr[1:0];
      SZ_H, SZ_HU: eff_lo = {req_addr[1], 1'b0};
      default:     eff_lo = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    req_err = 1'b0;
    case (eff_size)
      SZ_H, SZ_HU: req_err = req_addr[0];
      SZ_W:        req_err = |req_addr[1:0];
      default:     req_err = 1'b0;
    endcase
    if (req_size inside {3'b011, 3'b110, 3'b111}) req_err = 1'b1;
  end
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    case (eff_size)
      SZ_B, SZ_BU: wdata_rep = {4{req_wdata[7:0]}};
      SZ_H, SZ_HU: wdata_rep = {2{req_wdata[15:0]}};
      default:     wdata_rep = req_wdata;
    endcase
  end

  assign mask = lane_mask(eff_size, eff_lo);

  load_ext u_load_ext (
    .word    (mem[idx]),
    .size    (eff_size),
    .addr_lo (eff_lo),
    .result  (ext_data)
  );

  assign acc_data = (req_write || req_err) ? 32'h0 : ext_data;

  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Outputs are registered from the next state so RESP drives the pulse directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      pend_data <= 32'h0;
      pend_err  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            cnt <= CNT_INIT;
            if (LATENCY == 1) begin
              state     <= RESP;
              req_ready <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_data;
              rsp_err   <= req_err;
            end else begin
              state     <= BUSY;
              req_ready <= 1'b0;
              pend_data <= acc_data;
              pend_err  <= req_err;
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_data;
            rsp_err   <= pend_err;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - scoreboard bench for data_mem_resp
module tb_data_mem_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = 3'b010;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   count_en = 1'b0;
  int   low_cnt = 0;

  data_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (count_en && !req_ready) low_cnt = low_cnt + 1;
    checks = checks + 1;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_rsp: rdata=%h err=%b at cycle %0d, required no response", rsp_rdata, rsp_err, cyc);
      end else begin
        e = q.pop_front();
        if (rsp_rdata !== e.data || rsp_err !== e.err || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL %s: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   e.name, rsp_rdata, rsp_err, cyc, e.data, e.err, e.cyc);
        end
      end
    end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL idle_outputs: rdata=%h err=%b, required 0 and 0", rsp_rdata, rsp_err);
    end
  end

  task automatic send(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e,
                      input bit expect_rsp, input string name);
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (!req_ready) begin
      errors = errors + 1;
      $display("FAIL %s_accept: req_ready=0 after 20 cycles, required 1", name);
    end else if (expect_rsp) begin
      q.push_back('{exp_d, exp_e, cyc + LAT, name});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e, input string name);
    send(wr, sz, addr, wd, exp_d, exp_e, 1'b1, name);
    drain();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err", {31'b0, rsp_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    op(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    op(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
    op(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    op(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
    op(1'b1, 3'b000, 32'h11, 32'h55, 32'h0, 1'b0, "sb_11");
    op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_10_after_sb");

    count_en = 1'b1;
    low_cnt  = 0;
    send(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1, "burst_lw");
    send(1'b0, 3'b000, 32'h11, 32'h0, 32'h00000055, 1'b0, 1'b1, "burst_lb");
    send(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 1'b1, "burst_lhu");
    send(1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0, 1'b1, "burst_lbu");
    drain();
    count_en = 1'b0;
    chk("burst_ready_low_cycles", low_cnt, 32'd4);

    op(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, "sw_20_clear");
`ifdef DMEM_MISALIGN_TRAP_EN
    op(1'b1, 3'b001, 32'h21, 32'h1234, 32'h0, 1'b1, "sh_21_trap");
    op(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, "lw_20_unchanged");
    op(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, "illegal_size_trap");
    op(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, "lw_12_trap");
`else
    op(1'b1, 3'b001, 32'h21, 32'h1234, 32'h0, 1'b0, "sh_21_aligned");
    op(1'b0, 3'b010, 32'h20, 32'h0, 32'h00001234, 1'b0, "lw_20_written");
    op(1'b0, 3'b011, 32'h20, 32'h0, 32'h00001234, 1'b0, "illegal_size_as_w");
    op(1'b0, 3'b010, 32'h12, 32'h0, 32'hDEAD55EF, 1'b0, "lw_12_aligned");
`endif

    op(1'b1, 3'b010, 32'h30 + 32'd4096, 32'hCAFEF00D, 32'h0, 1'b0, "sw_wrap");
    op(1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, "lw_wrap");

    op(1'b1, 3'b010, 32'h40, 32'h77, 32'h0, 1'b0, "sw_40");
    send(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, "lw_dropped");
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 3'b010;
    req_addr  = 32'h40;
    req_wdata = 32'h11111111;
    #1;
    chk("midreset_ready", {31'b0, req_ready}, 32'h1);
    chk("midreset_valid", {31'b0, rsp_valid}, 32'h0);
    chk("midreset_rdata", rsp_rdata, 32'h0);
    chk("midreset_err", {31'b0, rsp_err}, 32'h0);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    op(1'b0, 3'b010, 32'h40, 32'h0, 32'h00000077, 1'b0, "lw_40_after_reset");
    op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw_10_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
